addsub_result_stage: RTL and testbench

//  Registered result/flag stage directly downstream of the 16-bit prefix add/sub unit.

---
 rtl/addsub_result_stage_pkg.sv | 16 +
 rtl/addsub_flag_calc.sv | 49 ++++
 rtl/addsub_result_stage.sv | 130 +++++++++++++
 tb/tb_addsub_result_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_result_stage_pkg.sv
// Shared definitions for the add/sub result stage.
//   FLAG_W          : width of the flag vector
//   FLG_C/V/Z/N     : bit positions of carry, overflow, zero, negative in flags_t
//   flags_t         : packed flag vector {C,V,Z,N}
package addsub_result_stage_pkg;

  localparam int FLAG_W = 4;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational flag derivation for the prefix add/sub unit.
// The adder itself is upstream; this block reconstructs the MSB carry-in from
// the operands and the sum, then derives carry-out and signed overflow.
// Ports:
//   in_a   : operand a as fed to the adder
//   in_b   : operand b before the adder's own inversion
//   in_sel : 0 = add, 1 = subtract (adder inverts b)
//   in_sum : adder output
//   flags  : {C,V,Z,N}
module addsub_flag_calc
  import addsub_result_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_sum,
  output flags_t           flags
);

  logic a_msb;
  logic bx_msb;
  logic c_msb;
  logic carry;

  // Only the MSBs of the operands matter; the lower bits are already folded
  // into in_sum by the adder.
  logic unused_lsbs;
  assign unused_lsbs = ^{in_a[WIDTH-2:0], in_b[WIDTH-2:0]};

  assign a_msb  = in_a[WIDTH-1];
  assign bx_msb = in_sel ? ~in_b[WIDTH-1] : in_b[WIDTH-1];

  // Carry into the MSB position, recovered from the MSB sum bit.
  assign c_msb  = in_sum[WIDTH-1] ^ a_msb ^ bx_msb;
  assign carry  = (a_msb & bx_msb) | (c_msb & (a_msb | bx_msb));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and infers a latch.
    flags        = '0;
    flags[FLG_C] = carry;
    flags[FLG_V] = carry ^ c_msb;
    flags[FLG_Z] = (in_sum == '0);
    flags[FLG_N] = in_sum[WIDTH-1];
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result/flag stage downstream of the 16-bit prefix add/sub unit.
// Accepts operands + combinational sum on a valid/ready input, derives
// {C,V,Z,N}, and buffers result+flags in a DEPTH-entry FIFO toward the consumer.
// Also keeps a sticky overflow bit and a completed-operation counter.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake; in_ready = FIFO not full (1 during reset)
//   in_a, in_b, in_sel    : operands and add/sub select as seen by the adder
//   in_cin                : adder carry-in (already reflected in in_sum)
//   in_sum                : adder output
//   out_valid / out_ready : output handshake on the FIFO head
//   out_sum, out_flags    : head result and flags {C,V,Z,N}
//   ovf_sticky, ovf_clr   : sticky overflow bit and its clear
//   op_count              : number of results popped, wrapping
module addsub_result_stage
  import addsub_result_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output flags_t           out_flags,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    flags_t           flags;
  } entry_t;

  // The carry-in is already folded into in_sum by the adder.
  logic unused_cin;
  assign unused_cin = in_cin;

  flags_t            flags;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] count;
  logic              push;
  logic              pop;
  entry_t            head;

  addsub_flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .in_a   (in_a),
    .in_b   (in_b),
    .in_sel (in_sel),
    .in_sum (in_sum),
    .flags  (flags)
  );

  // Full blocks input even if the head pops this cycle; keeps in_ready a pure
  // function of registered state (plus reset).
  assign in_ready  = reset | (count != FILL_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: the storage array has no reset; validity is tracked by count and the
  // pointers, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{sum: in_sum, flags: flags};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FILL_W'(1);
        2'b01:   count <= count - FILL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (push && flags[FLG_V]) begin
      // Set wins over a same-cycle clear.
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  // Head is driven purely from registered state. Masking with out_valid gives
  // zero outputs after reset without having to clear the storage.
  assign head      = mem[rd_ptr];
  assign out_sum   = out_valid ? head.sum   : '0;
  assign out_flags = out_valid ? head.flags : '0;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed self-checking bench for addsub_result_stage.
module tb_addsub_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sel;
  logic        in_cin;
  logic [15:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_flags;
  logic        ovf_sticky;
  logic        ovf_clr;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_result_stage #(
    .WIDTH (16),
    .DEPTH (2),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_cin     (in_cin),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic sel,
                        input logic cin, input logic [15:0] sum);
    in_a   = a;
    in_b   = b;
    in_sel = sel;
    in_cin = cin;
    in_sum = sum;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    set_op(16'h0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Reset state
    tick();
    tick();
    check("rst_in_ready_held", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'h0);
    check("rst_out_flags", 32'(out_flags), 32'h0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 0x7FFF + 0x0001 -> 0x8000, C=0 V=1 Z=0 N=1
    set_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_sum", 32'(out_sum), 32'h8000);
    check("t1_flags", 32'(out_flags), 32'h5);
    check("t1_ovf", 32'(ovf_sticky), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_op_count", 32'(op_count), 32'd1);
    check("t1_empty", 32'(out_valid), 32'd0);

    // 2: 0x0005 - 0x0005 -> 0x0000, C=1 V=0 Z=1 N=0
    set_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_sum", 32'(out_sum), 32'h0);
    check("t2_flags", 32'(out_flags), 32'hA);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_op_count", 32'(op_count), 32'd2);

    // 3: fill with out_ready=0, third push refused, drain in order
    set_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003);   // flags 0
    in_valid = 1'b1;
    tick();
    check("t3_ready_after1", 32'(in_ready), 32'd1);
    set_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000);   // flags C V Z = 0xE
    tick();
    check("t3_ready_full", 32'(in_ready), 32'd0);
    check("t3_head_sum", 32'(out_sum), 32'h0003);
    set_op(16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002);
    tick();
    in_valid = 1'b0;
    check("t3_still_full", 32'(in_ready), 32'd0);
    check("t3_head_stable_sum", 32'(out_sum), 32'h0003);
    check("t3_head_stable_flags", 32'(out_flags), 32'h0);
    out_ready = 1'b1;
    tick();
    check("t3_pop1_sum", 32'(out_sum), 32'h0000);
    check("t3_pop1_flags", 32'(out_flags), 32'hE);
    check("t3_pop1_count", 32'(op_count), 32'd3);
    tick();
    out_ready = 1'b0;
    check("t3_drained", 32'(out_valid), 32'd0);
    check("t3_op_count", 32'(op_count), 32'd4);

    // 4: steady push+pop at count=1 for 10 cycles
    set_op(16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100);
    in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(16'h0200 + 16'(i), 16'h0000, 1'b0, 1'b0, 16'h0200 + 16'(i));
      check("t4_in_ready", 32'(in_ready), 32'd1);
      check("t4_head", 32'(out_sum), (i == 0) ? 32'h0100 : 32'h0200 + 32'(i - 1));
      tick();
    end
    in_valid = 1'b0;
    check("t4_valid_after", 32'(out_valid), 32'd1);
    check("t4_last_head", 32'(out_sum), 32'h0209);
    check("t4_op_count", 32'(op_count), 32'd14);
    tick();
    out_ready = 1'b0;
    check("t4_drained", 32'(out_valid), 32'd0);
    check("t4_op_count_final", 32'(op_count), 32'd15);

    // 5: sticky overflow set/clear priority
    ovf_clr = 1'b1;
    tick();
    check("t5_clr_alone_a", 32'(ovf_sticky), 32'd0);
    set_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_set_wins", 32'(ovf_sticky), 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("t5_clr_alone_b", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_full", 32'(in_ready), 32'd0);
    check("t5_ovf_again", 32'(ovf_sticky), 32'd1);

    // 6: reset while full with out_ready=1 and in_valid=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    reset     = 1'b1;
    #1;
    check("t6_ready_in_reset", 32'(in_ready), 32'd1);
    tick();
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_op_count", 32'(op_count), 32'd0);
    check("t6_ovf", 32'(ovf_sticky), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_out_sum", 32'(out_sum), 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("t6_post_valid", 32'(out_valid), 32'd0);
    check("t6_post_count", 32'(op_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
